// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the program-counter generator
package pc_gen_pkg;
    typedef logic [31:0] addr_t;
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} pc_gen_state_e;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-address (pc) and redirect decoupled ports of pc_gen
//   pc_valid/pc_ready/pc_addr       : fetch address stream to instr_fetch
//   redir_valid/redir_ready/redir_addr : redirect target from execute/commit
//   master = pc_gen side, slave = environment side
interface pc_gen_if;
    import pc_gen_pkg::*;
    logic  pc_valid;
    logic  pc_ready;
    addr_t pc_addr;
    logic  redir_valid;
    logic  redir_ready;
    addr_t redir_addr;
    modport master (output pc_valid, pc_addr, redir_ready,
                    input  pc_ready, redir_valid, redir_addr);
    modport slave  (input  pc_valid, pc_addr, redir_ready,
                    output pc_ready, redir_valid, redir_addr);
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator issuing sequential word-aligned fetch addresses
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pc (out) and redirect (in) decoupled ports
//   halt     : level; stop issuing once the current offer completes
//   flush    : one-cycle pulse on every accepted redirect
//   issued   : count of pc fires since reset
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter addr_t RESET_VECTOR = 32'h8000_0000,
    parameter int    BOOT_CYCLES  = 2,
    parameter int    STEP         = INSTR_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    pc_gen_if.master    bus,
    input  logic        halt,
    output logic        flush,
    output logic [31:0] issued
);
    pc_gen_state_e state_q, state_d;
    addr_t         cur_q;
    logic [3:0]    boot_cnt_q;
    logic [31:0]   issued_q;
    logic          redir_fire, pc_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_BOOT;
        else     state_q <= state_d;
    end

    // A redirect in S_HALT keeps the FSM halted even if halt drops that cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = (boot_cnt_q == 4'(BOOT_CYCLES - 1)) ? S_RUN : S_BOOT;
            S_RUN:   state_d = (halt && (pc_fire || !bus.pc_valid)) ? S_HALT : S_RUN;
            S_HALT:  state_d = (!halt && !redir_fire) ? S_RUN : S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    // Redirect always wins: it withdraws any pending offer in the same cycle the
    // flush tells instr_fetch to discard.
    always_comb begin
        redir_fire      = bus.redir_valid && !rst;
        flush           = redir_fire;
        bus.redir_ready = 1'b1;
        bus.pc_valid    = (state_q == S_RUN) && !bus.redir_valid;
        bus.pc_addr     = cur_q;
        pc_fire         = bus.pc_valid && bus.pc_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q      <= RESET_VECTOR;
            boot_cnt_q <= '0;
            issued_q   <= '0;
        end else begin
            if (redir_fire)   cur_q <= {bus.redir_addr[31:2], 2'b00};
            else if (pc_fire) cur_q <= cur_q + addr_t'(STEP);
            if (state_q == S_BOOT) boot_cnt_q <= boot_cnt_q + 4'd1;
            if (pc_fire) issued_q <= issued_q + 32'd1;
        end
    end

    assign issued = issued_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        flush;
    logic [31:0] issued;
    int          tests = 0;
    int          failed = 0;

    pc_gen_if bus();

    pc_gen dut (.clk(clk), .rst(rst), .bus(bus), .halt(halt), .flush(flush), .issued(issued));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_to_run(input logic rdy);
        tick();
        rst = 1'b1; halt = 1'b0; bus.redir_valid = 1'b0; bus.redir_addr = '0; bus.pc_ready = rdy;
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        bus.pc_ready = 1'b1; bus.redir_valid = 1'b0; bus.redir_addr = '0;
        rst = 1'b1;
        tick();
        tests++; if (bus.pc_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", bus.pc_valid); end
        tests++; if (flush !== 1'b0) begin failed++; $display("FAIL reset_flush: got %b want 0", flush); end
        tests++; if (issued !== 32'd0) begin failed++; $display("FAIL reset_issued: got %h want 0", issued); end
        tests++; if (bus.redir_ready !== 1'b1) begin failed++; $display("FAIL reset_rready: got %b want 1", bus.redir_ready); end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        #1;
        tests++; if (bus.pc_valid !== 1'b0) begin failed++; $display("FAIL boot0_valid: got %b want 0", bus.pc_valid); end
        tick();
        tests++; if (bus.pc_valid !== 1'b0) begin failed++; $display("FAIL boot1_valid: got %b want 0", bus.pc_valid); end
        tick();
        tests++; if (bus.pc_valid !== 1'b1 || bus.pc_addr !== 32'h8000_0000) begin failed++; $display("FAIL seq0: got v=%b %h want v=1 80000000", bus.pc_valid, bus.pc_addr); end
        tick();
        tests++; if (bus.pc_addr !== 32'h8000_0004) begin failed++; $display("FAIL seq1: got %h want 80000004", bus.pc_addr); end
        tick();
        tests++; if (bus.pc_addr !== 32'h8000_0008) begin failed++; $display("FAIL seq2: got %h want 80000008", bus.pc_addr); end
        tick();
        tests++; if (issued !== 32'd3) begin failed++; $display("FAIL seq_issued: got %0d want 3", issued); end
    endtask

    task automatic test_backpressure();
        reset_to_run(1'b0);
        for (int i = 0; i < 5; i++) begin
            tests++; if (bus.pc_valid !== 1'b1 || bus.pc_addr !== 32'h8000_0000) begin failed++; $display("FAIL hold%0d: got v=%b %h want v=1 80000000", i, bus.pc_valid, bus.pc_addr); end
            tick();
        end
        bus.pc_ready = 1'b1;
        tick();
        bus.pc_ready = 1'b0;
        #1;
        tests++; if (bus.pc_addr !== 32'h8000_0004 || issued !== 32'd1) begin failed++; $display("FAIL bp_after: got %h issued=%0d want 80000004 issued=1", bus.pc_addr, issued); end
    endtask

    task automatic test_redirect_pending();
        bus.redir_valid = 1'b1; bus.redir_addr = 32'h8000_0100;
        #1;
        tests++; if (flush !== 1'b1 || bus.pc_valid !== 1'b0) begin failed++; $display("FAIL redir_cycle: got flush=%b v=%b want flush=1 v=0", flush, bus.pc_valid); end
        tick();
        bus.redir_valid = 1'b0;
        #1;
        tests++; if (flush !== 1'b0 || bus.pc_valid !== 1'b1 || bus.pc_addr !== 32'h8000_0100) begin failed++; $display("FAIL redir_next: got flush=%b v=%b %h want 0 1 80000100", flush, bus.pc_valid, bus.pc_addr); end
        tests++; if (issued !== 32'd1) begin failed++; $display("FAIL redir_issued: got %0d want 1", issued); end
    endtask

    task automatic test_redirect_boot();
        tick();
        rst = 1'b1; bus.pc_ready = 1'b1;
        tick();
        rst = 1'b0; bus.redir_valid = 1'b1; bus.redir_addr = 32'h8000_0203;
        #1;
        tests++; if (flush !== 1'b1 || bus.pc_valid !== 1'b0) begin failed++; $display("FAIL boot_redir: got flush=%b v=%b want 1 0", flush, bus.pc_valid); end
        tick();
        bus.redir_valid = 1'b0;
        #1;
        tests++; if (flush !== 1'b0 || bus.pc_valid !== 1'b0) begin failed++; $display("FAIL boot_redir_b1: got flush=%b v=%b want 0 0", flush, bus.pc_valid); end
        tick();
        tests++; if (bus.pc_valid !== 1'b1 || bus.pc_addr !== 32'h8000_0200) begin failed++; $display("FAIL boot_first: got v=%b %h want 1 80000200", bus.pc_valid, bus.pc_addr); end
        tick();
        tests++; if (bus.pc_addr !== 32'h8000_0204 || issued !== 32'd1) begin failed++; $display("FAIL boot_second: got %h issued=%0d want 80000204 1", bus.pc_addr, issued); end
    endtask

    task automatic test_halt();
        reset_to_run(1'b0);
        halt = 1'b1;
        #1;
        tests++; if (bus.pc_valid !== 1'b1 || bus.pc_addr !== 32'h8000_0000) begin failed++; $display("FAIL halt_hold0: got v=%b %h want 1 80000000", bus.pc_valid, bus.pc_addr); end
        tick();
        tests++; if (bus.pc_valid !== 1'b1 || bus.pc_addr !== 32'h8000_0000) begin failed++; $display("FAIL halt_hold1: got v=%b %h want 1 80000000", bus.pc_valid, bus.pc_addr); end
        bus.pc_ready = 1'b1;
        tick();
        tests++; if (bus.pc_valid !== 1'b0 || issued !== 32'd1) begin failed++; $display("FAIL halt_stop: got v=%b issued=%0d want 0 1", bus.pc_valid, issued); end
        tick();
        tests++; if (bus.pc_valid !== 1'b0 || issued !== 32'd1) begin failed++; $display("FAIL halt_idle: got v=%b issued=%0d want 0 1", bus.pc_valid, issued); end
        halt = 1'b0;
        tick();
        tests++; if (bus.pc_valid !== 1'b1 || bus.pc_addr !== 32'h8000_0004) begin failed++; $display("FAIL halt_resume: got v=%b %h want 1 80000004", bus.pc_valid, bus.pc_addr); end
    endtask

    task automatic test_back_to_back();
        reset_to_run(1'b0);
        bus.redir_valid = 1'b1; bus.redir_addr = 32'h8000_1000;
        #1;
        tests++; if (flush !== 1'b1) begin failed++; $display("FAIL b2b_flush0: got %b want 1", flush); end
        tick();
        bus.redir_addr = 32'h8000_2000;
        #1;
        tests++; if (flush !== 1'b1 || bus.pc_valid !== 1'b0) begin failed++; $display("FAIL b2b_flush1: got flush=%b v=%b want 1 0", flush, bus.pc_valid); end
        tick();
        bus.redir_valid = 1'b0;
        #1;
        tests++; if (bus.pc_valid !== 1'b1 || bus.pc_addr !== 32'h8000_2000 || issued !== 32'd0) begin failed++; $display("FAIL b2b_last: got v=%b %h issued=%0d want 1 80002000 0", bus.pc_valid, bus.pc_addr, issued); end
    endtask

    task automatic test_wrap_and_async_reset();
        reset_to_run(1'b1);
        bus.redir_valid = 1'b1; bus.redir_addr = 32'hFFFF_FFFC;
        tick();
        bus.redir_valid = 1'b0;
        #1;
        tests++; if (bus.pc_valid !== 1'b1 || bus.pc_addr !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_pre: got v=%b %h want 1 fffffffc", bus.pc_valid, bus.pc_addr); end
        tick();
        tests++; if (bus.pc_addr !== 32'h0000_0000 || issued !== 32'd1) begin failed++; $display("FAIL wrap: got %h issued=%0d want 00000000 1", bus.pc_addr, issued); end
        tick();
        tests++; if (bus.pc_addr !== 32'h0000_0004 || issued !== 32'd2) begin failed++; $display("FAIL wrap_next: got %h issued=%0d want 00000004 2", bus.pc_addr, issued); end
        rst = 1'b1; bus.redir_valid = 1'b1; bus.redir_addr = 32'h1234_5678;
        #1;
        tests++; if (bus.pc_valid !== 1'b0 || flush !== 1'b0 || issued !== 32'd0 || bus.pc_addr !== 32'h8000_0000) begin failed++; $display("FAIL async_rst: got v=%b flush=%b issued=%0d %h want 0 0 0 80000000", bus.pc_valid, flush, issued, bus.pc_addr); end
        bus.redir_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_pending();
        test_redirect_boot();
        test_halt();
        test_back_to_back();
        test_wrap_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
